// File: rtl/dtw_min_finder.sv
// dtw_min_finder: scans ref_len DTW cost words from the sink FIFO, tracks the minimum
// cost and its first position, and reports whether that minimum beats the threshold.
module dtw_min_finder #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CWIDTH-1:0] i_ref_len,
    input  logic [DWIDTH-1:0] i_threshold,
    output logic              o_fifo_rden,
    input  logic              i_fifo_empty,
    input  logic [DWIDTH-1:0] i_fifo_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [DWIDTH-1:0] o_min_cost,
    output logic [CWIDTH-1:0] o_min_pos,
    output logic              o_match
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            r_state, w_next;
    logic [CWIDTH-1:0] r_len, r_issued, r_received, r_min_pos;
    logic [DWIDTH-1:0] r_thr, r_min_cost, w_min_nxt;
    logic              r_valid, r_match, w_upd, w_last;
    // Issue compares against the latched length, so a full-range ref_len never wraps.
    always_comb begin
        o_fifo_rden = (r_state == RUN) && !i_fifo_empty && (r_issued < r_len);
        w_upd       = r_valid && (i_fifo_data < r_min_cost);
        w_min_nxt   = w_upd ? i_fifo_data : r_min_cost;
        w_last      = r_valid && (r_received == r_len - CWIDTH'(1));
        w_next      = (r_state == IDLE) ? (i_start ? ((i_ref_len == '0) ? DONE : RUN) : IDLE) :
                      (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_thr      <= '0;
            r_issued   <= '0;
            r_received <= '0;
            r_valid    <= 1'b0;
            r_min_cost <= '1;
            r_min_pos  <= '0;
            r_match    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= o_fifo_rden;
            if (r_state == IDLE && i_start) begin
                r_len      <= i_ref_len;
                r_thr      <= i_threshold;
                r_issued   <= '0;
                r_received <= '0;
                r_min_cost <= '1;
                r_min_pos  <= '0;
                r_match    <= 1'b0;
            end else begin
                if (o_fifo_rden) r_issued <= r_issued + CWIDTH'(1);
                if (r_valid) r_received <= r_received + CWIDTH'(1);
                if (w_upd) begin
                    r_min_cost <= i_fifo_data;
                    r_min_pos  <= r_received;
                end
                // Match uses the minimum including the word arriving on this edge.
                if (r_state == RUN && w_last) r_match <= (w_min_nxt < r_thr);
            end
        end
    end
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);
    assign o_min_cost = r_min_cost;
    assign o_min_pos  = r_min_pos;
    assign o_match    = r_match;
endmodule

// File: tb/tb_dtw_min_finder.sv
// tb_dtw_min_finder: scoreboard bench with a one-cycle-latency FIFO model.
module tb_dtw_min_finder;
    logic        clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_fifo_empty;
    logic [31:0] i_ref_len = '0, i_threshold = '0, i_fifo_data;
    logic        o_fifo_rden, o_busy, o_done, o_match;
    logic [31:0] o_min_cost, o_min_pos;
    int total = 0, bad = 0;

    typedef struct {logic [31:0] cost; logic [31:0] pos; logic match;} exp_t;
    exp_t exp_q[$];
    logic [31:0] costs[$];

    logic [31:0] mem[0:255];
    int  wp = 0, rp = 0, gcnt = 0;
    bit  fifo_clr = 0, gate_en = 0;
    logic force_empty = 1'b0;

    always #5 clk = ~clk;

    assign i_fifo_empty = force_empty || (rp >= wp);

    always @(posedge clk) begin
        if (fifo_clr) rp <= 0;
        else if (o_fifo_rden && rp < wp) begin
            i_fifo_data <= mem[rp];
            rp <= rp + 1;
        end
        force_empty <= gate_en && (gcnt % 6 == 5);
        gcnt <= gcnt + 1;
    end

    dtw_min_finder dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_ref_len(i_ref_len),
        .i_threshold(i_threshold), .o_fifo_rden(o_fifo_rden), .i_fifo_empty(i_fifo_empty),
        .i_fifo_data(i_fifo_data), .o_busy(o_busy), .o_done(o_done),
        .o_min_cost(o_min_cost), .o_min_pos(o_min_pos), .o_match(o_match)
    );

    // Loads costs plus one sentinel word that must never be read.
    task automatic load_fifo();
        @(negedge clk);
        foreach (costs[i]) mem[i] = costs[i];
        mem[costs.size()] = 32'h0;
        wp = costs.size() + 1;
        fifo_clr = 1;
        @(negedge clk);
        fifo_clr = 0;
    endtask

    task automatic run_scan(input int len, input logic [31:0] thr, input bit gate, input bit poke,
                            input string nm);
        exp_t e;
        int nr = 0, viol = 0, lat = 0;
        bit seen = 0;
        logic [31:0] held;
        e.cost = '1;
        e.pos = 0;
        for (int i = 0; i < len; i++)
            if (costs[i] < e.cost) begin e.cost = costs[i]; e.pos = i; end
        e.match = e.cost < thr;
        exp_q.push_back(e);
        load_fifo();
        gate_en = gate;
        @(negedge clk);
        i_start = 1; i_ref_len = len; i_threshold = thr;
        for (int k = 1; k <= len * 3 + 20; k++) begin
            @(negedge clk);
            i_start = poke && k == 3;
            if (poke && k == 3) begin i_ref_len = 2; i_threshold = 0; end
            if (o_fifo_rden) nr++;
            if (o_fifo_rden && i_fifo_empty) viol++;
            if (o_done) begin lat = k; seen = 1; break; end
        end
        i_start = 0;
        gate_en = 0;
        e = exp_q.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s done_timeout got=none want=done", nm);
        end else begin
            total += 8;
            if (o_min_cost !== e.cost) begin bad++; $display("FAIL %s min_cost got=%0h want=%0h", nm, o_min_cost, e.cost); end
            if (o_min_pos !== e.pos) begin bad++; $display("FAIL %s min_pos got=%0d want=%0d", nm, o_min_pos, e.pos); end
            if (o_match !== e.match) begin bad++; $display("FAIL %s match got=%0b want=%0b", nm, o_match, e.match); end
            if (o_busy !== 1'b1) begin bad++; $display("FAIL %s busy_at_done got=%0b want=1", nm, o_busy); end
            if (nr != len) begin bad++; $display("FAIL %s rden_count got=%0d want=%0d", nm, nr, len); end
            if (viol != 0) begin bad++; $display("FAIL %s rden_while_empty got=%0d want=0", nm, viol); end
            if (rp != len) begin bad++; $display("FAIL %s words_consumed got=%0d want=%0d", nm, rp, len); end
            if (!gate && lat != (len == 0 ? 1 : len + 2)) begin
                bad++; $display("FAIL %s done_latency got=%0d want=%0d", nm, lat, len == 0 ? 1 : len + 2);
            end
            held = o_min_cost;
            @(negedge clk);
            total++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_min_cost !== held) begin
                bad++; $display("FAIL %s after_done done=%0b busy=%0b min=%0h want 0,0,%0h", nm, o_done, o_busy, o_min_cost, held);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        total++;
        if ({o_fifo_rden, o_busy, o_done, o_match} !== 4'b0 || o_min_cost !== 32'hFFFFFFFF || o_min_pos !== 0) begin
            bad++;
            $display("FAIL reset got rden=%0b busy=%0b done=%0b match=%0b min=%0h pos=%0d want 0,0,0,0,ffffffff,0",
                     o_fifo_rden, o_busy, o_done, o_match, o_min_cost, o_min_pos);
        end
        rst = 0;
    endtask

    task automatic test_basic();
        costs = '{40, 12, 30, 12, 50};
        run_scan(5, 20, 0, 0, "basic");
    endtask

    task automatic test_threshold();
        costs = '{40, 12, 30, 12, 50};
        run_scan(5, 12, 0, 0, "thr_eq");
        run_scan(5, 13, 0, 0, "thr_above");
        costs = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        run_scan(3, 32'hFFFFFFFF, 0, 0, "all_ones");
        costs = '{32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        run_scan(3, 32'hFFFFFFFF, 0, 0, "thr_max");
    endtask

    task automatic test_gating();
        costs = '{7, 3, 9, 3};
        run_scan(4, 5, 0, 0, "ungated4");
        run_scan(4, 5, 1, 0, "gated4");
        costs = '{90, 80, 70, 60, 55, 61, 54, 54, 70, 99, 53, 100};
        run_scan(12, 54, 1, 0, "gated12");
    endtask

    task automatic test_zero_len();
        costs.delete();
        run_scan(0, 32'h7FFFFFFF, 0, 0, "zero_len");
    endtask

    task automatic test_reset_mid();
        int nr = 0;
        bit ok = 1;
        costs.delete();
        for (int i = 0; i < 100; i++) costs.push_back(32'((i * 37) % 91 + 5));
        load_fifo();
        @(negedge clk);
        i_start = 1; i_ref_len = 100; i_threshold = 20;
        for (int k = 1; k < 300; k++) begin
            @(negedge clk);
            i_start = 0;
            if (o_fifo_rden) nr++;
            if (nr == 40) break;
        end
        rst = 1;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_fifo_rden !== 1'b0 || o_min_cost !== 32'hFFFFFFFF || o_min_pos !== 0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got busy=%0b rden=%0b min=%0h pos=%0d done=%0b want 0,0,ffffffff,0,0",
                     o_busy, o_fifo_rden, o_min_cost, o_min_pos, o_done);
        end
        rst = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_fifo_rden !== 1'b0 || o_busy !== 1'b0) ok = 0;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL reset_mid_quiet got activity want rden=0 busy=0"); end
        costs = '{21, 8, 8};
        run_scan(3, 9, 0, 0, "after_reset");
    endtask

    task automatic test_start_while_busy();
        costs = '{9, 8, 2, 5, 6, 7};
        run_scan(6, 3, 0, 1, "start_busy");
    endtask

    task automatic test_back_to_back();
        costs = '{3, 1, 4, 1, 5, 9, 2, 6};
        run_scan(8, 2, 0, 0, "b2b_a");
        costs = '{100, 200, 50};
        run_scan(3, 50, 0, 0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_gating();
        test_zero_len();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dtw_min_finder.md
# dtw_min_finder

Downstream consumer of dtw_core's sink FIFO. In reference mode it reads one unsigned cost word per reference position and tracks the minimum cost and its position. It compares that minimum against a programmable threshold and reports a single match/no-match decision per read. This turns the raw cost stream into the selective-sequencing verdict handed to the AXI control layer.

## Interface
- DWIDTH, 32, sink FIFO word width; each word is one unsigned DTW cost.
- CWIDTH, 32, width of the position counters and ref_len.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- ref_len  in  CWIDTH  number of cost words to consume; latched on accepted start.
- threshold  in  DWIDTH  match threshold; latched on accepted start.
- fifo_rden  out  1  read strobe to the sink FIFO (standard FIFO, data valid the cycle after rden).
- fifo_empty  in  1  sink FIFO empty flag.
- fifo_data  in  DWIDTH  sink FIFO read data.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when the result is final.
- min_cost  out  DWIDTH  minimum cost seen; held until the next accepted start.
- min_pos  out  CWIDTH  zero-based index of the first word achieving min_cost.
- match  out  1  min_cost < threshold (strict); valid with done, held afterwards.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch ref_len and threshold;
  - issued=0, received=0, min_cost=all-ones, min_pos=0, match=0;
  - go to RUN, or to DONE directly if ref_len==0.
- start in RUN or DONE is ignored.
- RUN, issue side:
  - fifo_rden = !fifo_empty && (issued < ref_len), combinational from registered issued and the latched length;
  - issued increments on each rden.
- RUN, receive side:
  - a registered valid flag tracks rden one cycle late;
  - when valid, if fifo_data < min_cost then min_cost<=fifo_data and min_pos<=received;
  - received increments.
- Ties keep the earlier position (strict less-than).
- A cost of all-ones never updates the minimum, so min_pos stays 0 if every word is all-ones.
- When a valid word arrives with received == ref_len-1, the state goes to DONE on the next edge.
- DONE lasts one cycle:
  - done=1;
  - match = (min_cost < threshold), registered on entry to DONE;
  - next state is IDLE.
- No rden is ever issued beyond ref_len words; leftover FIFO contents are not touched.
- Counter arithmetic is unsigned CWIDTH; ref_len up to 2^CWIDTH-1 is supported without wrap, because comparisons use issued < ref_len rather than equality on an incremented value.

## Timing
- Reset values: fifo_rden=0, busy=0, done=0, min_cost=all-ones, min_pos=0, match=0, state IDLE, counters 0.
- Reset mid-scan aborts immediately: all outputs return to reset values on the next edge, and no further rden is issued.
- start is accepted at edge T; busy is high from T+1; the first rden can be asserted in cycle T+1.
- Last rden in cycle L: data is compared at edge L+1, DONE is entered at edge L+2, and done is high during cycle L+2 (2-cycle latency from last rden to done).
- Ungated stream: ref_len=N with the FIFO never empty gives N consecutive rden cycles, with done N+2 cycles after start is accepted.
- fifo_empty is sampled combinationally each cycle; an empty cycle simply stalls issue, and in-flight data still arrives one cycle after its rden.
- ref_len==0: busy and done are both high in cycle T+1, with match=0 and min_cost=all-ones; no rden is issued.
- Outputs min_cost, min_pos and match change only during RUN/DONE and are stable in IDLE.

## Test plan
- Basic stream: ref_len=5, costs 40,12,30,12,50, threshold=20, FIFO never empty -> five contiguous rden pulses; done 7 cycles after start; min_cost=12, min_pos=1 (tie keeps first), match=1.
- Threshold boundary: same data, threshold=12 -> match=0 (strict); with threshold=13 -> match=1.
- Empty gating: ref_len=4, fifo_empty toggled high for 1 cycle every 6 -> rden never asserted while empty; exactly 4 rden total; results identical to the ungated run.
- Zero length: ref_len=0 -> no rden; done and busy pulse in cycle T+1; min_cost=0xFFFFFFFF, match=0.
- Reset mid-scan: ref_len=100, assert rst after 40 words -> next cycle busy=0, rden=0, min_cost=0xFFFFFFFF; a subsequent start with ref_len=3 produces correct fresh results.
- Start while busy: pulse start again during RUN with different ref_len/threshold -> ignored; the original scan completes with the original parameters.
